// File: rtl/fir_pkg.sv
// Shared FIR helpers: width derivation, clog2, saturate-and-slice of the accumulator.
// Latency: n/a (pure functions). Backpressure: n/a. Build option: FIR_SATURATE_EN selects clamp vs wrap.
package fir_pkg;

`ifdef FIR_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ww_p(input int ww_in, input int ww_cf);
    return ww_in + ww_cf;
  endfunction

  function automatic int ww_acc(input int ww_in, input int ww_cf, input int n_taps);
    return ww_in + ww_cf + clog2(n_taps);
  endfunction

  // acc arrives sign-extended to 64 bits; the low wo bits of the result are the output.
  // The slice acc[wp-1 -: wo] is a floor shift; overflow means acc does not fit in wp bits.
  function automatic logic [63:0] slice_out(input logic signed [63:0] acc,
                                            input int wp, input int wo);
    logic signed [63:0] hi;
    logic        [63:0] res;
    res = 64'(acc >>> (wp - wo));
    hi  = acc >>> (wp - 1);
    if (SAT_EN && (hi != '0) && (hi != '1)) begin
      if (acc[63]) res = 64'd1 << (wo - 1);
      else         res = (64'd1 << (wo - 1)) - 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/filtro_fir_coef_bank.sv
// Coefficient register file: N_TAPS x WW_COEFF, reset to zero, one write port, all taps read in parallel.
// Latency: a write is visible on the read port the cycle after its edge. Backpressure: none, writes always land.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int N_TAPS   = 4,
  parameter int WW_COEFF = 8,
  localparam int AW      = clog2(N_TAPS)
) (
  input  logic                             clk,
  input  logic                             i_srst,
  input  logic                             i_we,
  input  logic [AW-1:0]                    i_addr,
  input  logic [WW_COEFF-1:0]              i_data,
  output logic [N_TAPS-1:0][WW_COEFF-1:0]  o_coef
);

  // Out-of-range addresses simply match no tap.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      o_coef <= '0;
    end else if (i_we) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (int'(i_addr) == k) o_coef[k] <= i_data;
      end
    end
  end

endmodule

// File: rtl/filtro_fir_pipe.sv
// Pipelined N-tap direct-form FIR with writable coefficients; FIR_SATURATE_EN clamps the output slice.
// Latency: sample accepted at edge k is on o_os_dv after edge k+1. Backpressure: o_is_rfd = i_en & (~o_os_dv | i_os_rfd), stall holds all stages.
module filtro_fir_pipe
  import fir_pkg::*;
#(
  parameter int N_TAPS    = 4,
  parameter int WW_INPUT  = 8,
  parameter int WW_COEFF  = 8,
  parameter int WW_OUTPUT = 8,
  localparam int AW       = clog2(N_TAPS),
  localparam int WW_P     = ww_p(WW_INPUT, WW_COEFF),
  localparam int WW_ACC   = ww_acc(WW_INPUT, WW_COEFF, N_TAPS)
) (
  input  logic                        clk,
  input  logic                        i_srst,
  input  logic                        i_en,
  input  logic signed [WW_INPUT-1:0]  i_is_data,
  input  logic                        i_is_dv,
  output logic                        o_is_rfd,
  output logic [WW_OUTPUT-1:0]        o_os_data,
  output logic                        o_os_dv,
  input  logic                        i_os_rfd,
  input  logic                        i_coef_we,
  input  logic [AW-1:0]               i_coef_addr,
  input  logic [WW_COEFF-1:0]         i_coef_data
);

  logic                              adv;
  logic [N_TAPS-1:0][WW_COEFF-1:0]   coef;
  logic signed [WW_INPUT-1:0]        dly  [N_TAPS-1];
  logic signed [WW_INPUT-1:0]        tap  [N_TAPS];
  logic signed [WW_P-1:0]            prod [N_TAPS];
  logic                              v1;
  logic signed [WW_ACC-1:0]          acc;

  assign adv      = i_en & (~o_os_dv | i_os_rfd);
  assign o_is_rfd = adv;

  fir_coef_bank #(
    .N_TAPS   (N_TAPS),
    .WW_COEFF (WW_COEFF)
  ) u_coef_bank (
    .clk    (clk),
    .i_srst (i_srst),
    .i_we   (i_coef_we),
    .i_addr (i_coef_addr),
    .i_data (i_coef_data),
    .o_coef (coef)
  );

  // tap[0] is the incoming sample, tap[k] is x[n-k] held in the delay line.
  always_comb begin
    tap[0] = i_is_data;
    for (int k = 1; k < N_TAPS; k++) tap[k] = dly[k-1];
  end

  // Products use the coefficients registered before this edge, so a same-edge write lands next sample.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      v1 <= 1'b0;
      for (int k = 0; k < N_TAPS; k++)     prod[k] <= '0;
      for (int k = 0; k < N_TAPS - 1; k++) dly[k]  <= '0;
    end else if (adv) begin
      v1 <= i_is_dv;
      for (int k = 0; k < N_TAPS; k++)
        prod[k] <= WW_P'(tap[k]) * WW_P'($signed(coef[k]));
      if (i_is_dv) begin
        dly[0] <= i_is_data;
        for (int k = 1; k < N_TAPS - 1; k++) dly[k] <= dly[k-1];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) acc = acc + WW_ACC'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      o_os_data <= '0;
      o_os_dv   <= 1'b0;
    end else if (adv) begin
      o_os_data <= WW_OUTPUT'(slice_out(64'(acc), WW_P, WW_OUTPUT));
      o_os_dv   <= v1;
    end
  end

endmodule

// File: tb/tb_filtro_fir_pipe.sv
// Directed bench for filtro_fir_pipe (4 taps, 8/8/8) with a sample-history model and literal anchors.
module tb_filtro_fir_pipe;

  logic       clk = 1'b0;
  logic       i_srst, i_en, i_is_dv, i_os_rfd, i_coef_we;
  logic [7:0] i_is_data, i_coef_data;
  logic [1:0] i_coef_addr;
  logic       o_is_rfd, o_os_dv;
  logic [7:0] o_os_data;

  always #5 clk = ~clk;

  filtro_fir_pipe #(
    .N_TAPS(4), .WW_INPUT(8), .WW_COEFF(8), .WW_OUTPUT(8)
  ) dut (
    .clk(clk), .i_srst(i_srst), .i_en(i_en),
    .i_is_data(i_is_data), .i_is_dv(i_is_dv), .o_is_rfd(o_is_rfd),
    .o_os_data(o_os_data), .o_os_dv(o_os_dv), .i_os_rfd(i_os_rfd),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data)
  );

  int         n_run  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exq[$];
  int         hist[3];
  int         cm[4];
  int         m_acc;
  int         m_x;
  bit         run_chk = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Ideal filter output: exact integer sum, then floor to the top byte of 16 bits.
  function automatic logic [7:0] model_out(input int acc);
`ifdef FIR_SATURATE_EN
    if (acc > 32767)  return 8'h7F;
    if (acc < -32768) return 8'h80;
`endif
    return 8'(acc >>> 8);
  endfunction

  always @(negedge clk) begin
    if (run_chk) begin
      if (o_os_dv) begin
        if (exp_q.size() == 0) check("spurious_dv", 1, 0);
        else                   check("stream_data", o_os_data, exp_q[0]);
      end
      check("rfd_rule", o_is_rfd, i_en & (~o_os_dv | i_os_rfd));
      if (i_srst) begin
        exp_q.delete();
        hist = '{0, 0, 0};
        cm   = '{0, 0, 0, 0};
      end else begin
        if (o_os_dv && i_en && i_os_rfd && exp_q.size() > 0) begin
          got_q.push_back(o_os_data);
          void'(exp_q.pop_front());
        end
        if (i_is_dv && o_is_rfd) begin
          m_x   = int'($signed(i_is_data));
          m_acc = cm[0]*m_x + cm[1]*hist[0] + cm[2]*hist[1] + cm[3]*hist[2];
          exp_q.push_back(model_out(m_acc));
          hist[2] = hist[1];
          hist[1] = hist[0];
          hist[0] = m_x;
        end
        if (i_coef_we) cm[i_coef_addr] = int'($signed(i_coef_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [7:0] d);
    i_coef_we = 1'b1; i_coef_addr = a; i_coef_data = d;
    tick();
    i_coef_we = 1'b0;
  endtask

  task automatic base_coefs();
    wr_coef(2'd0, 8'h80); wr_coef(2'd1, 8'h40);
    wr_coef(2'd2, 8'hE0); wr_coef(2'd3, 8'h10);
  endtask

  task automatic send(input logic [7:0] d);
    bit done;
    done = 1'b0;
    i_is_data = d; i_is_dv = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (o_is_rfd) done = 1'b1;
      tick();
    end
    i_is_dv = 1'b0;
    if (!done) check("send_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    i_is_dv = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && exp_q.size() > 0; t++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic expect_got(input string name, input logic [7:0] ex[$]);
    check({name, "_count"}, got_q.size(), ex.size());
    for (int i = 0; i < ex.size() && i < got_q.size(); i++) check(name, got_q[i], ex[i]);
  endtask

  logic [7:0] s3[10] = '{8'h01, 8'h10, 8'hF0, 8'h7F, 8'h80, 8'h33, 8'hC5, 8'h0A, 8'h00, 8'h5A};
  int         g4[10] = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 2};
  logic [7:0] d0;

  initial begin
    i_srst = 1'b1; i_en = 1'b1; i_is_dv = 1'b0; i_is_data = '0;
    i_os_rfd = 1'b1; i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    tick();
    run_chk = 1'b1;
    tick();
    i_srst = 1'b0;
    @(negedge clk);
    check("reset_dv", o_os_dv, 0);
    check("reset_data", o_os_data, 0);
    check("reset_rfd", o_is_rfd, 1);
    tick();

    // 1: impulse response and latency
    base_coefs();
    got_q.delete();
    send(8'h40);
    @(negedge clk); check("t1_dv_after_accept_edge", o_os_dv, 0);
    @(negedge clk); check("t1_dv_next_edge", o_os_dv, 1);
    check("t1_first_data", o_os_data, 8'hE0);
    tick();
    repeat (4) send(8'h00);
    drain();
    exq = '{8'hE0, 8'h10, 8'hF8, 8'h04, 8'h00};
    expect_got("t1_impulse", exq);

    // 2: overflow behaviour
    for (int k = 0; k < 4; k++) wr_coef(2'(k), 8'h80);
    got_q.delete();
    repeat (6) send(8'h80);
    drain();
`ifdef FIR_SATURATE_EN
    exq = '{8'h40, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
`else
    exq = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h00, 8'h00};
`endif
    expect_got("t2_overflow", exq);

    // 3: downstream back-pressure for 5 clocks mid-stream
    base_coefs();
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) send(s3[i]);
      end
      begin
        repeat (4) tick();
        i_os_rfd = 1'b0;
        @(negedge clk);
        d0 = o_os_data;
        check("t3_stall_dv_start", o_os_dv, 1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("t3_stall_rfd", o_is_rfd, 0);
          check("t3_stall_data", o_os_data, d0);
          check("t3_stall_dv", o_os_dv, 1);
        end
        @(posedge clk); #1;
        i_os_rfd = 1'b1;
      end
    join
    drain();
    check("t3_no_loss_dup", got_q.size(), 10);

    // 4: input gaps plus global enable low for 3 clocks
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          idle(g4[i]);
          send(s3[9-i]);
        end
      end
      begin
        repeat (6) tick();
        i_en = 1'b0;
        @(negedge clk); check("t4_en_rfd", o_is_rfd, 0);
        repeat (3) tick();
        i_en = 1'b1;
      end
    join
    drain();
    check("t4_count", got_q.size(), 10);

    // 5: coefficient write on the same edge as an accept
    repeat (3) send(8'h00);
    drain();
    got_q.delete();
    i_coef_we = 1'b1; i_coef_addr = 2'd0; i_coef_data = 8'h40;
    send(8'h40);
    i_coef_we = 1'b0;
    repeat (3) send(8'h00);
    send(8'h40);
    drain();
    exq = '{8'hE0, 8'h10, 8'hF8, 8'h04, 8'h10};
    expect_got("t5_coef_update", exq);

    // 6: reset with both stages valid
    base_coefs();
    send(8'h11); send(8'h22); send(8'h33);
    i_srst = 1'b1;
    @(negedge clk); check("t6_pre_reset_dv", o_os_dv, 1);
    tick();
    i_srst = 1'b0;
    @(negedge clk);
    check("t6_post_reset_dv", o_os_dv, 0);
    check("t6_post_reset_data", o_os_data, 0);
    tick();
    got_q.delete();
    send(8'h40); send(8'h7F); send(8'h80); send(8'h00);
    drain();
    exq = '{8'h00, 8'h00, 8'h00, 8'h00};
    expect_got("t6_zero_coefs", exq);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_run);
    $fatal(1);
  end

endmodule
